// File: rtl/agc_pkg.sv
// agc_pkg: shared definitions for the AGC sequencer.
//   - agc_state_e : state encoding, also driven onto the 'state' debug port
//                   (IDLE=0, DETECT=1, ADJUST=2, SETTLE=3, LOCKED=4, DONE=5)
//   - DIR_UP/DIR_DN : gain step direction constants (1 = increase gain)
package agc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DETECT = 3'd1,
    ST_ADJUST = 3'd2,
    ST_SETTLE = 3'd3,
    ST_LOCKED = 3'd4,
    ST_DONE   = 3'd5
  } agc_state_e;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/agc_gain_step.sv
// agc_gain_step: combinational saturating add/subtract of a step to a gain code.
// Ports:
//   gain      in  GAIN_W : current gain code
//   step      in  GAIN_W : step magnitude
//   up        in  1      : DIR_UP adds, DIR_DN subtracts
//   gain_next out GAIN_W : stepped gain, clamped to [0, 2^GAIN_W-1]
//   clip      out 1      : the result was limited at a rail (landing exactly
//                          on a rail is not a clip)
module agc_gain_step
  import agc_pkg::*;
#(
  parameter int GAIN_W = 6
) (
  input  logic [GAIN_W-1:0] gain,
  input  logic [GAIN_W-1:0] step,
  input  logic              up,
  output logic [GAIN_W-1:0] gain_next,
  output logic              clip
);

  logic [GAIN_W:0] sum;

  // One extra bit catches overflow past the top rail.
  assign sum = {1'b0, gain} + {1'b0, step};

  always_comb begin
    gain_next = gain;
    clip      = 1'b0;
    if (up == DIR_UP) begin
      if (sum[GAIN_W]) begin
        gain_next = {GAIN_W{1'b1}};
        clip      = 1'b1;
      end else begin
        gain_next = sum[GAIN_W-1:0];
      end
    end else begin
      if (step > gain) begin
        gain_next = '0;
        clip      = 1'b1;
      end else begin
        gain_next = gain - step;
      end
    end
  end

endmodule

// File: rtl/agc_controller_p.sv
// agc_controller_p: automatic-gain-control sequencer.
// Collects 2^DET_W valid amplitude samples, evaluates the last one against the
// window [target-tol, target+tol] (clamped to the measurement range) and steps
// the gain code up or down, then waits SETTLE_CYC cycles before measuring
// again. LOCK_N consecutive in-window evaluations lock the loop; 'done' from
// the preamble detector freezes it terminally until reset.
// Ports:
//   clk, RESETn          : clock, asynchronous active-low reset
//   en                   : run enable, low returns to IDLE
//   done                 : preamble done, enters terminal DONE state
//   meas, meas_valid     : amplitude sample and its qualifier
//   target, tol          : window centre and half-width (static while en=1)
//   gain                 : current gain code (register)
//   adjust               : high during the single ADJUST cycle
//   up_dn                : step direction during ADJUST, 1 otherwise
//   detect_mode, locked  : state decodes for DETECT and LOCKED
//   saturated            : last gain step was clipped at a rail (register)
//   state                : current state encoding (agc_state_e)
// Handshake: meas is consumed on every clock edge where meas_valid=1 and the
// state is DETECT; there is no back-pressure, samples arriving in any other
// state are dropped.
module agc_controller_p
  import agc_pkg::*;
#(
  parameter int DET_W       = 4,
  parameter int MEAS_W      = 8,
  parameter int GAIN_W      = 6,
  parameter int GAIN_INIT   = 2 ** (GAIN_W - 1),
  parameter int STEP_FINE   = 1,
  parameter int STEP_COARSE = 4,
  parameter int COARSE_THR  = 32,
  parameter int SETTLE_CYC  = 8,
  parameter int LOCK_N      = 2
) (
  input  logic              clk,
  input  logic              RESETn,
  input  logic              en,
  input  logic              done,
  input  logic [MEAS_W-1:0] meas,
  input  logic              meas_valid,
  input  logic [MEAS_W-1:0] target,
  input  logic [MEAS_W-1:0] tol,
  output logic [GAIN_W-1:0] gain,
  output logic              adjust,
  output logic              up_dn,
  output logic              detect_mode,
  output logic              locked,
  output logic              saturated,
  output logic [2:0]        state
);

  localparam int SETTLE_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int LOCK_W      = $clog2(LOCK_N + 1);
  localparam int SETTLE_LST  = SETTLE_CYC - 1;

  localparam logic [DET_W-1:0]    DET_ONE     = 1;
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = 1;
  localparam logic [LOCK_W-1:0]   LOCK_ONE    = 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_LST[SETTLE_W-1:0];
  localparam logic [LOCK_W-1:0]   LOCK_TGT    = LOCK_N[LOCK_W-1:0];
  localparam logic [MEAS_W:0]     THR_X       = COARSE_THR[MEAS_W:0];
  localparam logic [MEAS_W:0]     M_ONE       = 1;
  localparam logic [GAIN_W-1:0]   G_INIT      = GAIN_INIT[GAIN_W-1:0];
  localparam logic [GAIN_W-1:0]   G_FINE      = STEP_FINE[GAIN_W-1:0];
  localparam logic [GAIN_W-1:0]   G_COARSE    = STEP_COARSE[GAIN_W-1:0];

  agc_state_e          state_q, state_d;
  logic [DET_W-1:0]    det_cnt_q, det_cnt_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic                dir_q, dir_d;
  logic                coarse_q, coarse_d;
  logic [GAIN_W-1:0]   gain_q, gain_d;
  logic                sat_q, sat_d;

  // Window arithmetic is one bit wider than the measurement so the clamps at
  // 0 and 2^MEAS_W-1 and the signed error never wrap.
  logic [MEAS_W:0] meas_x, target_x, tol_x, sum_x, lo, hi, err, err_mag;
  logic            in_win, below;
  logic [LOCK_W-1:0] lock_inc;

  assign meas_x   = {1'b0, meas};
  assign target_x = {1'b0, target};
  assign tol_x    = {1'b0, tol};
  assign sum_x    = target_x + tol_x;
  assign lo       = (tol_x > target_x) ? '0 : (target_x - tol_x);
  assign hi       = sum_x[MEAS_W] ? {1'b0, {MEAS_W{1'b1}}} : sum_x;
  assign err      = meas_x - target_x;
  assign err_mag  = err[MEAS_W] ? (~err + M_ONE) : err;
  assign below    = meas_x < lo;
  assign in_win   = !below && (meas_x <= hi);
  assign lock_inc = lock_cnt_q + LOCK_ONE;

  logic [GAIN_W-1:0] step_gain;
  logic              step_clip;

  agc_gain_step #(
    .GAIN_W (GAIN_W)
  ) u_gain_step (
    .gain      (gain_q),
    .step      (coarse_q ? G_COARSE : G_FINE),
    .up        (dir_q),
    .gain_next (step_gain),
    .clip      (step_clip)
  );

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      state_q      <= ST_IDLE;
      det_cnt_q    <= '0;
      lock_cnt_q   <= '0;
      settle_cnt_q <= '0;
      dir_q        <= DIR_UP;
      coarse_q     <= 1'b0;
      gain_q       <= G_INIT;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      det_cnt_q    <= det_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      dir_q        <= dir_d;
      coarse_q     <= coarse_d;
      gain_q       <= gain_d;
      sat_q        <= sat_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    det_cnt_d    = det_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    settle_cnt_d = settle_cnt_q;
    dir_d        = dir_q;
    coarse_d     = coarse_q;
    gain_d       = gain_q;
    sat_d        = sat_q;

    if (state_q == ST_DONE) begin
      // Terminal: only reset leaves DONE, en is ignored.
      state_d = ST_DONE;
    end else if (done && (state_q != ST_IDLE)) begin
      // Pre-empts a pending evaluation or ADJUST, so no step happens.
      state_d = ST_DONE;
    end else if (!en) begin
      state_d      = ST_IDLE;
      det_cnt_d    = '0;
      lock_cnt_d   = '0;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          det_cnt_d    = '0;
          lock_cnt_d   = '0;
          settle_cnt_d = '0;
          state_d      = ST_DETECT;
        end
        ST_DETECT: begin
          if (meas_valid) begin
            if (det_cnt_q == {DET_W{1'b1}}) begin
              det_cnt_d = '0;
              if (in_win) begin
                lock_cnt_d = lock_inc;
                if (lock_inc == LOCK_TGT) state_d = ST_LOCKED;
              end else begin
                lock_cnt_d = '0;
                dir_d      = below ? DIR_UP : DIR_DN;
                coarse_d   = err_mag > THR_X;
                state_d    = ST_ADJUST;
              end
            end else begin
              det_cnt_d = det_cnt_q + DET_ONE;
            end
          end
        end
        ST_ADJUST: begin
          gain_d       = step_gain;
          sat_d        = step_clip;
          settle_cnt_d = '0;
          state_d      = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            settle_cnt_d = '0;
            det_cnt_d    = '0;
            state_d      = ST_DETECT;
          end else begin
            settle_cnt_d = settle_cnt_q + SETTLE_ONE;
          end
        end
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  assign gain        = gain_q;
  assign saturated   = sat_q;
  assign state       = state_q;
  assign adjust      = (state_q == ST_ADJUST);
  assign up_dn       = (state_q == ST_ADJUST) ? dir_q : DIR_UP;
  assign detect_mode = (state_q == ST_DETECT);
  assign locked      = (state_q == ST_LOCKED);

endmodule
